// File: rtl/fetch_queue_if.sv
// Instruction-memory handshake between the fetch queue (master) and the
// instruction memory (slave). One request outstanding at a time; ack may
// arrive in the same cycle the request is raised.
interface fetch_queue_if #(
   parameter int RV = 32
);
   logic          ifetch_req;
   logic [RV-1:0] ifetch_addr;
   logic          ifetch_ack;
   logic [15:0]   ifetch_data;

   modport master (
      output ifetch_req,
      output ifetch_addr,
      input  ifetch_ack,
      input  ifetch_data
   );

   modport slave (
      input  ifetch_req,
      input  ifetch_addr,
      output ifetch_ack,
      output ifetch_data
   );
endinterface

// File: rtl/fetch_queue.sv
// Halfword instruction fetch queue with redirect handling.
// Optional feature macro: FETCH_PREFETCH_EN (queue depth 2, fetch ahead while
// the queue holds an entry). Without it the queue holds a single entry.
//
// state  | meaning
// -------+------------------------------------------------------------
// S_IDLE | no request outstanding
// S_REQ  | request outstanding, its data will be pushed on ack
// S_DROP | request outstanding after a redirect, its data is discarded
module fetch_queue #(
   parameter int            RV       = 32,
   parameter logic [RV-1:0] RESET_PC = '0
) (
   input  logic          clk,
   input  logic          reset,
   input  logic          pc_load,
   input  logic [RV-1:0] pc_load_addr,
   input  logic          stall,
   fetch_queue_if.master imem,
   output logic [15:0]   ins,
   output logic          idone,
   output logic [RV-1:0] ins_pc
);

`ifdef FETCH_PREFETCH_EN
   localparam int Q = 2;
`else
   localparam int Q = 1;
`endif
   localparam int CW = $clog2(Q + 1);

   typedef enum logic [1:0] {
      S_IDLE,
      S_REQ,
      S_DROP
   } state_t;

   state_t        state_q, state_d;
   logic [RV-1:0] fpc_q, fpc_d;
   logic [RV-1:0] hold_q, hold_d;
   logic [CW-1:0] cnt_q, cnt_d;
   logic [15:0]   q_ins_q [Q];
   logic [15:0]   q_ins_d [Q];
   logic [RV-1:0] q_pc_q  [Q];
   logic [RV-1:0] q_pc_d  [Q];

   logic [RV-1:0] fpc_al;
   logic          push;
   logic          pop;
   logic          space;
   logic [CW-1:0] wr_idx;

   // Aligned fetch PC; while dropping, the stale request address is held so
   // the bus stays stable even though fpc already points at the new target.
   always_comb begin
      fpc_al           = fpc_q & ~RV'(1);
      imem.ifetch_req  = (state_q != S_IDLE);
      imem.ifetch_addr = (state_q == S_DROP) ? hold_q : fpc_al;
      pop              = (cnt_q != '0) && !stall && !pc_load;
      push             = (state_q == S_REQ) && imem.ifetch_ack && !pc_load;
      idone            = pop;
      ins              = q_ins_q[0];
      ins_pc           = q_pc_q[0];
   end

   // Queue occupancy and storage: pop shifts toward the head, push lands
   // behind the surviving entries so FIFO order holds on push+pop.
   always_comb begin
      q_ins_d = q_ins_q;
      q_pc_d  = q_pc_q;
      wr_idx  = cnt_q - CW'(pop);
      if (pc_load) begin
         cnt_d = '0;
      end else begin
         cnt_d = cnt_q + CW'(push) - CW'(pop);
      end
      if (pop) begin
         for (int i = 0; i < Q - 1; i++) begin
            q_ins_d[i] = q_ins_q[i+1];
            q_pc_d[i]  = q_pc_q[i+1];
         end
      end
      for (int i = 0; i < Q; i++) begin
         if (push && (i == int'(wr_idx))) begin
            q_ins_d[i] = imem.ifetch_data;
            q_pc_d[i]  = fpc_al;
         end
      end
      space = (cnt_d < CW'(Q));
   end

   // Next-state, fetch PC and drop-address hold.
   always_comb begin
      state_d = state_q;
      fpc_d   = fpc_q;
      hold_d  = hold_q;
      if (pc_load) begin
         fpc_d = pc_load_addr & ~RV'(1);
      end else if (push) begin
         fpc_d = fpc_q + RV'(2);
      end
      case (state_q)
         S_IDLE: begin
            if (space) state_d = S_REQ;
         end
         S_REQ: begin
            if (pc_load) begin
               if (imem.ifetch_ack) begin
                  state_d = S_REQ;
               end else begin
                  state_d = S_DROP;
                  hold_d  = fpc_al;
               end
            end else if (imem.ifetch_ack) begin
               state_d = space ? S_REQ : S_IDLE;
            end
         end
         S_DROP: begin
            if (imem.ifetch_ack) state_d = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase
   end

   // Control state with asynchronous reset.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q <= S_IDLE;
         fpc_q   <= RESET_PC;
         hold_q  <= '0;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         fpc_q   <= fpc_d;
         hold_q  <= hold_d;
         cnt_q   <= cnt_d;
      end
   end

   // Queue payload; contents are don't-care while the count is zero.
   always_ff @(posedge clk) begin
      q_ins_q <= q_ins_d;
      q_pc_q  <= q_pc_d;
   end

endmodule

// File: tb/tb_fetch_queue.sv
// Directed bench for fetch_queue. Expected behaviour adapts to the
// FETCH_PREFETCH_EN build option (queue depth 2 vs 1).
module tb_fetch_queue;

`ifdef FETCH_PREFETCH_EN
   localparam int Q  = 2;
   localparam bit PF = 1'b1;
`else
   localparam int Q  = 1;
   localparam bit PF = 1'b0;
`endif

   logic        clk;
   logic        reset;
   logic        pc_load;
   logic [31:0] pc_load_addr;
   logic        stall;
   logic [15:0] ins;
   logic        idone;
   logic [31:0] ins_pc;
   logic        auto_ack;
   logic        man_ack;

   int total = 0;
   int bad   = 0;

   fetch_queue_if #(.RV(32)) mem_if ();

   function automatic logic [15:0] mem_word(input logic [31:0] a);
      return a[15:0] ^ 16'hA5A5;
   endfunction

   assign mem_if.ifetch_ack  = auto_ack ? mem_if.ifetch_req : man_ack;
   assign mem_if.ifetch_data = auto_ack ? mem_word(mem_if.ifetch_addr) : 16'hDEAD;

   fetch_queue #(.RV(32), .RESET_PC(32'h0)) dut (
      .clk          (clk),
      .reset        (reset),
      .pc_load      (pc_load),
      .pc_load_addr (pc_load_addr),
      .stall        (stall),
      .imem         (mem_if),
      .ins          (ins),
      .idone        (idone),
      .ins_pc       (ins_pc)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic apply_reset();
      @(negedge clk);
      reset = 1'b0; pc_load = 1'b0; stall = 1'b0;
      auto_ack = 1'b1; man_ack = 1'b0; pc_load_addr = '0;
      @(negedge clk);
      @(negedge clk);
      reset = 1'b1;
   endtask

   task automatic test_reset();
      repeat (2) @(negedge clk);
      #1;
      total++; if (mem_if.ifetch_req !== 1'b0) begin bad++; $display("FAIL rst_req: got %b want 0", mem_if.ifetch_req); end
      total++; if (idone !== 1'b0) begin bad++; $display("FAIL rst_idone: got %b want 0", idone); end
      total++; if (mem_if.ifetch_addr !== 32'h0) begin bad++; $display("FAIL rst_addr: got %h want 0", mem_if.ifetch_addr); end
      @(negedge clk);
      reset = 1'b1;
      #1;
      total++; if (mem_if.ifetch_req !== 1'b0) begin bad++; $display("FAIL rel_req0: got %b want 0", mem_if.ifetch_req); end
      @(negedge clk);
      #1;
      total++; if (mem_if.ifetch_req !== 1'b1 || mem_if.ifetch_addr !== 32'h0) begin
         bad++; $display("FAIL first_req: got req=%b addr=%h want req=1 addr=0", mem_if.ifetch_req, mem_if.ifetch_addr);
      end
   endtask

   task automatic test_stream();
      logic        e_req, e_done;
      logic [31:0] e_addr, e_pc;
      apply_reset();
      for (int k = 1; k <= 8; k++) begin
         @(negedge clk);
         #1;
         e_req  = PF ? 1'b1 : (k % 2 == 1);
         e_addr = PF ? 32'(2 * (k - 1)) : 32'(k - 1);
         e_done = PF ? (k >= 2) : (k % 2 == 0);
         e_pc   = PF ? 32'(2 * (k - 2)) : 32'(k - 2);
         total++; if (mem_if.ifetch_req !== e_req) begin bad++; $display("FAIL stream_req[%0d]: got %b want %b", k, mem_if.ifetch_req, e_req); end
         if (e_req) begin
            total++; if (mem_if.ifetch_addr !== e_addr) begin bad++; $display("FAIL stream_addr[%0d]: got %h want %h", k, mem_if.ifetch_addr, e_addr); end
         end
         total++; if (idone !== e_done) begin bad++; $display("FAIL stream_idone[%0d]: got %b want %b", k, idone, e_done); end
         if (e_done) begin
            total++; if (ins_pc !== e_pc || ins !== mem_word(e_pc)) begin
               bad++; $display("FAIL stream_ins[%0d]: got pc=%h ins=%h want pc=%h ins=%h", k, ins_pc, ins, e_pc, mem_word(e_pc));
            end
         end
      end
   endtask

   task automatic test_fill_stall();
      int nreq = 0;
      bit got = 0;
      apply_reset();
      stall = 1'b1;
      for (int k = 1; k <= 5; k++) begin
         @(negedge clk);
         #1;
         if (mem_if.ifetch_req && mem_if.ifetch_ack) nreq++;
         total++; if (idone !== 1'b0) begin bad++; $display("FAIL stall_idone[%0d]: got %b want 0", k, idone); end
      end
      total++; if (nreq != Q) begin bad++; $display("FAIL stall_nreq: got %0d want %0d", nreq, Q); end
      total++; if (mem_if.ifetch_req !== 1'b0) begin bad++; $display("FAIL stall_req_off: got %b want 0", mem_if.ifetch_req); end
      @(negedge clk);
      stall = 1'b0;
      #1;
      total++; if (idone !== 1'b1 || ins_pc !== 32'h0) begin bad++; $display("FAIL unstall_first: got idone=%b pc=%h want 1/0", idone, ins_pc); end
      for (int k = 0; k < 4 && !got; k++) begin
         @(negedge clk);
         #1;
         if (idone) begin
            got = 1;
            total++; if (ins_pc !== 32'h2) begin bad++; $display("FAIL unstall_second: got pc=%h want 2", ins_pc); end
         end
      end
      if (!got) begin total++; bad++; $display("FAIL unstall_timeout: got no idone want idone pc=2"); end
   endtask

   task automatic test_redirect_drop();
      apply_reset();
      auto_ack = 1'b0;
      @(negedge clk);
      #1;
      total++; if (mem_if.ifetch_req !== 1'b1 || mem_if.ifetch_addr !== 32'h0) begin
         bad++; $display("FAIL drop_req: got req=%b addr=%h want 1/0", mem_if.ifetch_req, mem_if.ifetch_addr);
      end
      @(negedge clk);
      pc_load = 1'b1; pc_load_addr = 32'h1235;
      #1;
      total++; if (idone !== 1'b0) begin bad++; $display("FAIL drop_idone_ld: got %b want 0", idone); end
      @(negedge clk);
      pc_load = 1'b0;
      #1;
      total++; if (mem_if.ifetch_req !== 1'b1 || mem_if.ifetch_addr !== 32'h0) begin
         bad++; $display("FAIL drop_hold: got req=%b addr=%h want 1/0", mem_if.ifetch_req, mem_if.ifetch_addr);
      end
      @(negedge clk);
      man_ack = 1'b1;
      #1;
      total++; if (idone !== 1'b0) begin bad++; $display("FAIL drop_ack_idone: got %b want 0", idone); end
      @(negedge clk);
      man_ack = 1'b0; auto_ack = 1'b1;
      #1;
      total++; if (mem_if.ifetch_req !== 1'b0 || idone !== 1'b0) begin
         bad++; $display("FAIL drop_idle: got req=%b idone=%b want 0/0", mem_if.ifetch_req, idone);
      end
      @(negedge clk);
      #1;
      total++; if (mem_if.ifetch_req !== 1'b1 || mem_if.ifetch_addr !== 32'h1234) begin
         bad++; $display("FAIL redir_addr: got req=%b addr=%h want 1/1234", mem_if.ifetch_req, mem_if.ifetch_addr);
      end
      @(negedge clk);
      #1;
      total++; if (idone !== 1'b1 || ins_pc !== 32'h1234 || ins !== mem_word(32'h1234)) begin
         bad++; $display("FAIL redir_ins: got idone=%b pc=%h ins=%h want 1/1234/%h", idone, ins_pc, ins, mem_word(32'h1234));
      end
   endtask

   task automatic test_load_ack();
      bit found = 0;
      apply_reset();
      pc_load_addr = 32'h100;
      for (int k = 1; k <= 6 && !found; k++) begin
         @(negedge clk);
         #1;
         if (k >= 2 && mem_if.ifetch_req) found = 1;
      end
      if (!found) begin
         total++; bad++; $display("FAIL ldack_timeout: got no request want request");
      end else begin
         pc_load = 1'b1;
         #1;
         total++; if (idone !== 1'b0) begin bad++; $display("FAIL ldack_idone: got %b want 0", idone); end
         @(negedge clk);
         pc_load = 1'b0;
         #1;
         total++; if (idone !== 1'b0) begin bad++; $display("FAIL ldack_flush: got idone=%b want 0", idone); end
         total++; if (mem_if.ifetch_req !== 1'b1 || mem_if.ifetch_addr !== 32'h100) begin
            bad++; $display("FAIL ldack_addr: got req=%b addr=%h want 1/100", mem_if.ifetch_req, mem_if.ifetch_addr);
         end
         @(negedge clk);
         #1;
         total++; if (idone !== 1'b1 || ins_pc !== 32'h100 || ins !== mem_word(32'h100)) begin
            bad++; $display("FAIL ldack_ins: got idone=%b pc=%h ins=%h want 1/100/%h", idone, ins_pc, ins, mem_word(32'h100));
         end
      end
   endtask

   task automatic test_wrap();
      logic [31:0] seq [2];
      logic [31:0] first_pc = 32'h5555_5555;
      int n = 0;
      bit seen = 0;
      apply_reset();
      @(negedge clk);
      pc_load = 1'b1; pc_load_addr = 32'hFFFF_FFFE;
      @(negedge clk);
      pc_load = 1'b0;
      for (int k = 0; k < 8; k++) begin
         if (k > 0) @(negedge clk);
         #1;
         if (mem_if.ifetch_req && mem_if.ifetch_ack && n < 2) begin seq[n] = mem_if.ifetch_addr; n++; end
         if (idone && !seen) begin seen = 1; first_pc = ins_pc; end
      end
      total++; if (n != 2) begin bad++; $display("FAIL wrap_nreq: got %0d want 2", n); end
      else begin
         total++; if (seq[0] !== 32'hFFFF_FFFE) begin bad++; $display("FAIL wrap_a0: got %h want fffffffe", seq[0]); end
         total++; if (seq[1] !== 32'h0) begin bad++; $display("FAIL wrap_a1: got %h want 0", seq[1]); end
      end
      total++; if (first_pc !== 32'hFFFF_FFFE) begin bad++; $display("FAIL wrap_ins_pc: got %h want fffffffe", first_pc); end
   endtask

   task automatic test_reset_mid();
      apply_reset();
      auto_ack = 1'b0;
      @(negedge clk);
      #1;
      total++; if (mem_if.ifetch_req !== 1'b1) begin bad++; $display("FAIL mid_req: got %b want 1", mem_if.ifetch_req); end
      #1;
      reset = 1'b0;
      #1;
      total++; if (mem_if.ifetch_req !== 1'b0 || idone !== 1'b0) begin
         bad++; $display("FAIL mid_drop: got req=%b idone=%b want 0/0", mem_if.ifetch_req, idone);
      end
      @(negedge clk);
      reset = 1'b1; auto_ack = 1'b1;
      #1;
      total++; if (mem_if.ifetch_req !== 1'b0) begin bad++; $display("FAIL mid_rel0: got %b want 0", mem_if.ifetch_req); end
      @(negedge clk);
      #1;
      total++; if (mem_if.ifetch_req !== 1'b1 || mem_if.ifetch_addr !== 32'h0) begin
         bad++; $display("FAIL mid_restart: got req=%b addr=%h want 1/0", mem_if.ifetch_req, mem_if.ifetch_addr);
      end
   endtask

   initial begin
      reset = 1'b0; pc_load = 1'b0; pc_load_addr = '0; stall = 1'b0;
      auto_ack = 1'b1; man_ack = 1'b0;
      test_reset();
      test_stream();
      test_fill_stall();
      test_redirect_drop();
      test_load_ack();
      test_wrap();
      test_reset_mid();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
